bcd_conv: RTL and testbench
===========================

Name: bcd_conv

Overview:
- Parametrised successor to the single-channel double-dabble converter: converts an IN_BITS binary word, unsigned or two's-complement, into NUM_DIGITS packed BCD digits.
- Adds a valid/ready handshake on both sides, adjusts all digits in parallel in one cycle per input bit, and reports sign, overflow and a leading-zero blanking mask.
- Sits between arithmetic/counter logic and the seven-segment/LCD/UART display drivers.

Parameters:
IN_BITS, 8, width of binary input (>=2)
NUM_DIGITS, 3, number of BCD output digits (>=1); output width is 4*NUM_DIGITS
SIGNED, 0, 1 = input is two's complement, convert magnitude and flag sign; 0 = unsigned

Ports:
in_clk  input  1  clock, rising edge
in_rst  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  input word offered
out_ready_in  output  1  converter can accept input (high only in Idle)
in_num  input  IN_BITS  binary input, sampled on accepting edge
out_valid  output  1  result available, held until consumed
in_ready  input  1  consumer accepts result
out_bcd  output  4*NUM_DIGITS  packed BCD, digit 0 in bits [3:0]
out_neg  output  1  input was negative (always 0 if SIGNED=0)
out_ovf  output  1  value did not fit; out_bcd holds magnitude mod 10^NUM_DIGITS
out_digit_en  output  NUM_DIGITS  bit i = 1 if digit i or any higher digit is non-zero; bit 0 always 1

Behaviour:
- Reset (in_rst=0, async): state=Idle; out_bcd=0, out_neg=0, out_ovf=0, out_valid=0, out_ready_in=1 once reset is released; bit counter and magnitude register cleared. Reset during Convert or Done aborts the conversion with no output.
- States: Idle, Convert, Done.
- Idle: out_ready_in=1. On an edge with in_valid=1:
  - latch magnitude (SIGNED=1 and in_num[MSB]=1: two's-complement negation, computed IN_BITS wide unsigned).
  - set neg, clear bcd and ovf, counter=IN_BITS-1, go to Convert.
- Convert, one edge per bit, MSB first:
  - adjust every nibble in parallel (+3 if >=5).
  - shift bcd left 1, shifting in magnitude[counter].
  - if the bit shifted out of bcd[4*NUM_DIGITS-1] is 1, set ovf (sticky).
  - counter=0 → Done; otherwise decrement the counter.
- Done: out_valid=1. out_bcd, out_neg and out_ovf are stable until an edge with in_ready=1, which moves to Idle. in_valid is ignored here; out_ready_in=0.
- Latency: out_valid rises exactly IN_BITS edges after the accepting edge. Throughput is one word per IN_BITS+2 cycles with no backpressure.
- in_valid while busy: not accepted, no side effect; the producer must hold the word.
- out_digit_en: combinational from out_bcd (prefix-OR of nibble non-zero, from the top digit down), with bit 0 forced to 1. Only meaningful while out_valid=1.
- Zero input, including zero with SIGNED=1: out_bcd=0, out_neg=0, out_digit_en=...001.
- Most-negative input (SIGNED=1, 1 followed by zeros): magnitude 2^(IN_BITS-1), which is correct because it fits IN_BITS unsigned.
- Width rules:
  - All adds are nibble-local 4-bit, with no carry between nibbles (adjusted nibble <=12, so the shifted value stays <=9 plus carry-out bit into the next nibble).
  - Counter width is $clog2(IN_BITS).

Decomposition:
- Package bcd_pkg:
  - t_bcd_conv_state enum {Idle, Convert, Done}
  - constant/function for digit count needed for a given bit width (ceil(IN_BITS*log10 2)), used by instantiators to size NUM_DIGITS.
- Sub-module bcd_digit_adj: combinational, NUM_DIGITS generic; takes the packed BCD vector and returns it with every nibble >=5 incremented by 3. Instantiated once in the Convert datapath.

Test Plan:
- IN_BITS=8, NUM_DIGITS=3, SIGNED=0, in_num=255 → out_bcd=0x255, out_ovf=0, out_neg=0, out_digit_en=111, out_valid exactly 8 edges after accept.
- IN_BITS=16, NUM_DIGITS=5, in_num=65535 then 1234 back to back with in_ready=1 → 0x65535 then 0x01234 with out_digit_en=01111.
- IN_BITS=8, NUM_DIGITS=2, in_num=255 → out_bcd=0x55, out_ovf=1; next input 42 → 0x42, out_ovf=0 (ovf cleared per word).
- SIGNED=1, IN_BITS=8, NUM_DIGITS=3: in_num=0x80 → out_neg=1, out_bcd=0x128; 0xFF → out_neg=1, 0x001, out_digit_en=001; 0x00 → out_neg=0, 0x000.
- Backpressure: in_ready low for 5 cycles in Done → out_valid and out_bcd stable, out_ready_in=0, in_valid pulses ignored; in_ready high → Idle next edge.
- Assert in_rst=0 midway through Convert → out_valid=0 and out_bcd=0 immediately (async); after release out_ready_in=1 and a fresh conversion of 99 gives 0x099.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared types and sizing helpers for the binary-to-BCD converter.
// Instantiators can size NUM_DIGITS with bcd_digits_for_bits().
package bcd_pkg;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Convert = 2'd1,
        Done    = 2'd2
    } t_bcd_conv_state;

    // ceil(bits * log10(2)), with log10(2) approximated as 0.30103
    function automatic int bcd_digits_for_bits(input int bits);
        return (bits * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_conv_if.sv
// Producer/consumer bundle for bcd_conv: input word handshake and result handshake.
// A word moves on an edge where in_valid and out_ready_in are both high; a result is
// consumed on an edge where out_valid and in_ready are both high. Valid never waits on ready.
interface bcd_conv_if #(
    parameter int IN_BITS    = 8,
    parameter int NUM_DIGITS = 3
);
    logic                    in_valid;
    logic                    out_ready_in;
    logic [IN_BITS-1:0]      in_num;
    logic                    out_valid;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] out_bcd;
    logic                    out_neg;
    logic                    out_ovf;
    logic [NUM_DIGITS-1:0]   out_digit_en;

    modport master (
        output in_valid, in_num, in_ready,
        input  out_ready_in, out_valid, out_bcd, out_neg, out_ovf, out_digit_en
    );

    modport slave (
        input  in_valid, in_num, in_ready,
        output out_ready_in, out_valid, out_bcd, out_neg, out_ovf, out_digit_en
    );
endinterface

// File: rtl/bcd_conv_digit_adj.sv
// Double-dabble pre-shift correction: every nibble >= 5 gets +3, all nibbles in parallel.
// Adds are nibble-local; an adjusted nibble never exceeds 12, so no carry crosses nibbles.
module bcd_digit_adj #(
    parameter int NUM_DIGITS = 3
) (
    input  logic [4*NUM_DIGITS-1:0] bcd,
    output logic [4*NUM_DIGITS-1:0] adjusted
);
    always_comb begin
        adjusted = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end
endmodule

// File: rtl/bcd_conv.sv
// Sequential binary-to-BCD converter, one input bit per cycle, MSB first.
// Signed inputs are converted as magnitude with a separate sign flag.
module bcd_conv
    import bcd_pkg::*;
#(
    parameter int IN_BITS    = 8,
    parameter int NUM_DIGITS = 3,
    parameter int SIGNED     = 0
) (
    input  logic            in_clk,
    input  logic            in_rst,
    bcd_conv_if.slave       bus,
    output t_bcd_conv_state state
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam logic [IN_BITS-1:0] ONE = IN_BITS'(1);

    logic [IN_BITS-1:0] mag;
    logic [CW-1:0]      cnt;
    logic [BW-1:0]      bcd;
    logic [BW-1:0]      adj;
    logic               neg;
    logic               ovf;
    logic               in_is_neg;
    logic [NUM_DIGITS-1:0] digit_en;

    bcd_digit_adj #(.NUM_DIGITS(NUM_DIGITS)) u_adj (
        .bcd      (bcd),
        .adjusted (adj)
    );

    assign in_is_neg = (SIGNED != 0) && bus.in_num[IN_BITS-1];

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state <= Idle;
            mag   <= '0;
            cnt   <= '0;
            bcd   <= '0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    if (bus.in_valid) begin
                        // Negating the most-negative value yields 2^(IN_BITS-1), valid as unsigned
                        mag   <= in_is_neg ? (~bus.in_num + ONE) : bus.in_num;
                        neg   <= in_is_neg;
                        bcd   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= CW'(IN_BITS - 1);
                        state <= Convert;
                    end
                end
                Convert: begin
                    bcd <= {adj[BW-2:0], mag[cnt]};
                    ovf <= ovf | adj[BW-1];
                    if (cnt == '0) begin
                        state <= Done;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                Done: begin
                    if (bus.in_ready) begin
                        state <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

    // Prefix-OR from the top digit down; the units digit is always shown
    always_comb begin
        logic seen;
        seen     = 1'b0;
        digit_en = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (bcd[4*i +: 4] != 4'd0);
            digit_en[i] = seen;
        end
        digit_en[0] = 1'b1;
    end

    assign bus.out_ready_in = (state == Idle);
    assign bus.out_valid    = (state == Done);
    assign bus.out_bcd      = bcd;
    assign bus.out_neg      = neg;
    assign bus.out_ovf      = ovf;
    assign bus.out_digit_en = digit_en;
endmodule

// File: tb/tb_bcd_conv.sv
// Directed bench for bcd_conv across four parameter sets sharing one clock and reset.
module tb_bcd_conv;
    import bcd_pkg::*;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    t_bcd_conv_state st_a, st_b, st_c, st_d;

    bcd_conv_if #(.IN_BITS(8),  .NUM_DIGITS(3)) ifa ();
    bcd_conv_if #(.IN_BITS(16), .NUM_DIGITS(5)) ifb ();
    bcd_conv_if #(.IN_BITS(8),  .NUM_DIGITS(2)) ifc ();
    bcd_conv_if #(.IN_BITS(8),  .NUM_DIGITS(3)) ifd ();

    bcd_conv #(.IN_BITS(8),  .NUM_DIGITS(3), .SIGNED(0)) dut_a (.in_clk(clk), .in_rst(rst_n), .bus(ifa), .state(st_a));
    bcd_conv #(.IN_BITS(16), .NUM_DIGITS(5), .SIGNED(0)) dut_b (.in_clk(clk), .in_rst(rst_n), .bus(ifb), .state(st_b));
    bcd_conv #(.IN_BITS(8),  .NUM_DIGITS(2), .SIGNED(0)) dut_c (.in_clk(clk), .in_rst(rst_n), .bus(ifc), .state(st_c));
    bcd_conv #(.IN_BITS(8),  .NUM_DIGITS(3), .SIGNED(1)) dut_d (.in_clk(clk), .in_rst(rst_n), .bus(ifd), .state(st_d));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Offer a word, then count edges after the accepting edge until out_valid.
    task automatic drive_a(input logic [7:0] num, output int lat);
        ifa.in_valid = 1'b1;
        ifa.in_num   = num;
        tick();
        ifa.in_valid = 1'b0;
        lat = 0;
        while (!ifa.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!ifa.out_valid) begin
            compared++; mismatched++;
            $display("FAIL timeout_a: out_valid=%0b after %0d edges, required 1", ifa.out_valid, lat);
        end
    endtask

    task automatic drive_c(input logic [7:0] num);
        int n;
        ifc.in_valid = 1'b1;
        ifc.in_num   = num;
        tick();
        ifc.in_valid = 1'b0;
        n = 0;
        while (!ifc.out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!ifc.out_valid) begin
            compared++; mismatched++;
            $display("FAIL timeout_c: out_valid=%0b after %0d edges, required 1", ifc.out_valid, n);
        end
    endtask

    task automatic drive_d(input logic [7:0] num);
        int n;
        ifd.in_valid = 1'b1;
        ifd.in_num   = num;
        tick();
        ifd.in_valid = 1'b0;
        n = 0;
        while (!ifd.out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!ifd.out_valid) begin
            compared++; mismatched++;
            $display("FAIL timeout_d: out_valid=%0b after %0d edges, required 1", ifd.out_valid, n);
        end
    endtask

    task automatic consume_a();
        ifa.in_ready = 1'b1; tick(); ifa.in_ready = 1'b0;
    endtask
    task automatic consume_c();
        ifc.in_ready = 1'b1; tick(); ifc.in_ready = 1'b0;
    endtask
    task automatic consume_d();
        ifd.in_ready = 1'b1; tick(); ifd.in_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        compared += 5;
        if (ifa.out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %0b want 0", ifa.out_valid); end
        if (ifa.out_bcd !== 12'h000) begin mismatched++; $display("FAIL rst_bcd: got %h want 000", ifa.out_bcd); end
        if (ifa.out_neg !== 1'b0) begin mismatched++; $display("FAIL rst_neg: got %0b want 0", ifa.out_neg); end
        if (ifa.out_ovf !== 1'b0) begin mismatched++; $display("FAIL rst_ovf: got %0b want 0", ifa.out_ovf); end
        if (st_a !== Idle) begin mismatched++; $display("FAIL rst_state: got %0d want %0d", st_a, Idle); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        compared += 4;
        if (ifa.out_ready_in !== 1'b1) begin mismatched++; $display("FAIL rst_ready_a: got %0b want 1", ifa.out_ready_in); end
        if (ifb.out_ready_in !== 1'b1) begin mismatched++; $display("FAIL rst_ready_b: got %0b want 1", ifb.out_ready_in); end
        if (ifc.out_ready_in !== 1'b1) begin mismatched++; $display("FAIL rst_ready_c: got %0b want 1", ifc.out_ready_in); end
        if (ifd.out_ready_in !== 1'b1) begin mismatched++; $display("FAIL rst_ready_d: got %0b want 1", ifd.out_ready_in); end
    endtask

    task automatic test_unsigned_255();
        int lat;
        drive_a(8'd255, lat);
        compared += 5;
        if (lat !== 8) begin mismatched++; $display("FAIL lat_255: got %0d edges want 8", lat); end
        if (ifa.out_bcd !== 12'h255) begin mismatched++; $display("FAIL bcd_255: got %h want 255", ifa.out_bcd); end
        if (ifa.out_ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_255: got %0b want 0", ifa.out_ovf); end
        if (ifa.out_neg !== 1'b0) begin mismatched++; $display("FAIL neg_255: got %0b want 0", ifa.out_neg); end
        if (ifa.out_digit_en !== 3'b111) begin mismatched++; $display("FAIL den_255: got %b want 111", ifa.out_digit_en); end
        consume_a();
        compared++;
        if (ifa.out_ready_in !== 1'b1) begin mismatched++; $display("FAIL idle_after_255: ready_in=%0b want 1", ifa.out_ready_in); end
    endtask

    task automatic test_back_to_back();
        int n;
        ifb.in_ready = 1'b1;
        ifb.in_valid = 1'b1;
        ifb.in_num   = 16'd65535;
        tick();
        ifb.in_num = 16'd1234;
        n = 0;
        while (!ifb.out_valid && n < 40) begin tick(); n++; end
        compared += 3;
        if (n !== 16) begin mismatched++; $display("FAIL lat_65535: got %0d edges want 16", n); end
        if (ifb.out_bcd !== 20'h65535) begin mismatched++; $display("FAIL bcd_65535: got %h want 65535", ifb.out_bcd); end
        if (ifb.out_digit_en !== 5'b11111) begin mismatched++; $display("FAIL den_65535: got %b want 11111", ifb.out_digit_en); end
        tick();
        compared++;
        if (ifb.out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_idle: out_valid=%0b want 0", ifb.out_valid); end
        tick();
        ifb.in_valid = 1'b0;
        n = 2;
        while (!ifb.out_valid && n < 60) begin tick(); n++; end
        compared += 3;
        if (n !== 18) begin mismatched++; $display("FAIL b2b_period: got %0d edges want 18", n); end
        if (ifb.out_bcd !== 20'h01234) begin mismatched++; $display("FAIL bcd_1234: got %h want 01234", ifb.out_bcd); end
        if (ifb.out_digit_en !== 5'b01111) begin mismatched++; $display("FAIL den_1234: got %b want 01111", ifb.out_digit_en); end
        tick();
        ifb.in_ready = 1'b0;
    endtask

    task automatic test_overflow();
        drive_c(8'd255);
        compared += 2;
        if (ifc.out_bcd !== 8'h55) begin mismatched++; $display("FAIL bcd_ovf255: got %h want 55", ifc.out_bcd); end
        if (ifc.out_ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_255: got %0b want 1", ifc.out_ovf); end
        consume_c();
        drive_c(8'd42);
        compared += 3;
        if (ifc.out_bcd !== 8'h42) begin mismatched++; $display("FAIL bcd_42: got %h want 42", ifc.out_bcd); end
        if (ifc.out_ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_42: got %0b want 0", ifc.out_ovf); end
        if (ifc.out_digit_en !== 2'b11) begin mismatched++; $display("FAIL den_42: got %b want 11", ifc.out_digit_en); end
        consume_c();
    endtask

    task automatic test_signed();
        drive_d(8'h80);
        compared += 3;
        if (ifd.out_neg !== 1'b1) begin mismatched++; $display("FAIL neg_80: got %0b want 1", ifd.out_neg); end
        if (ifd.out_bcd !== 12'h128) begin mismatched++; $display("FAIL bcd_80: got %h want 128", ifd.out_bcd); end
        if (ifd.out_ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_80: got %0b want 0", ifd.out_ovf); end
        consume_d();
        drive_d(8'hFF);
        compared += 3;
        if (ifd.out_neg !== 1'b1) begin mismatched++; $display("FAIL neg_ff: got %0b want 1", ifd.out_neg); end
        if (ifd.out_bcd !== 12'h001) begin mismatched++; $display("FAIL bcd_ff: got %h want 001", ifd.out_bcd); end
        if (ifd.out_digit_en !== 3'b001) begin mismatched++; $display("FAIL den_ff: got %b want 001", ifd.out_digit_en); end
        consume_d();
        drive_d(8'h00);
        compared += 3;
        if (ifd.out_neg !== 1'b0) begin mismatched++; $display("FAIL neg_00: got %0b want 0", ifd.out_neg); end
        if (ifd.out_bcd !== 12'h000) begin mismatched++; $display("FAIL bcd_00: got %h want 000", ifd.out_bcd); end
        if (ifd.out_digit_en !== 3'b001) begin mismatched++; $display("FAIL den_00: got %b want 001", ifd.out_digit_en); end
        consume_d();
    endtask

    task automatic test_backpressure();
        int lat;
        drive_a(8'd7, lat);
        for (int k = 0; k < 5; k++) begin
            ifa.in_valid = k[0];
            ifa.in_num   = 8'd200;
            tick();
            compared += 3;
            if (ifa.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid[%0d]: got %0b want 1", k, ifa.out_valid); end
            if (ifa.out_bcd !== 12'h007) begin mismatched++; $display("FAIL bp_bcd[%0d]: got %h want 007", k, ifa.out_bcd); end
            if (ifa.out_ready_in !== 1'b0) begin mismatched++; $display("FAIL bp_ready[%0d]: got %0b want 0", k, ifa.out_ready_in); end
        end
        ifa.in_valid = 1'b0;
        compared++;
        if (ifa.out_digit_en !== 3'b001) begin mismatched++; $display("FAIL den_7: got %b want 001", ifa.out_digit_en); end
        consume_a();
        compared += 2;
        if (ifa.out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release_valid: got %0b want 0", ifa.out_valid); end
        if (ifa.out_ready_in !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %0b want 1", ifa.out_ready_in); end
    endtask

    task automatic test_reset_mid();
        int lat;
        ifa.in_valid = 1'b1;
        ifa.in_num   = 8'd255;
        tick();
        ifa.in_valid = 1'b0;
        repeat (3) tick();
        compared++;
        if (st_a !== Convert) begin mismatched++; $display("FAIL mid_state: got %0d want %0d", st_a, Convert); end
        rst_n = 1'b0;
        #1;
        compared += 3;
        if (ifa.out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_valid: got %0b want 0", ifa.out_valid); end
        if (ifa.out_bcd !== 12'h000) begin mismatched++; $display("FAIL mid_rst_bcd: got %h want 000", ifa.out_bcd); end
        if (st_a !== Idle) begin mismatched++; $display("FAIL mid_rst_state: got %0d want %0d", st_a, Idle); end
        tick();
        rst_n = 1'b1;
        tick();
        compared++;
        if (ifa.out_ready_in !== 1'b1) begin mismatched++; $display("FAIL mid_rst_ready: got %0b want 1", ifa.out_ready_in); end
        drive_a(8'd99, lat);
        compared += 2;
        if (ifa.out_bcd !== 12'h099) begin mismatched++; $display("FAIL bcd_99: got %h want 099", ifa.out_bcd); end
        if (ifa.out_digit_en !== 3'b011) begin mismatched++; $display("FAIL den_99: got %b want 011", ifa.out_digit_en); end
        consume_a();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        compared   = 0;
        mismatched = 0;
        ifa.in_valid = 1'b0; ifa.in_ready = 1'b0; ifa.in_num = '0;
        ifb.in_valid = 1'b0; ifb.in_ready = 1'b0; ifb.in_num = '0;
        ifc.in_valid = 1'b0; ifc.in_ready = 1'b0; ifc.in_num = '0;
        ifd.in_valid = 1'b0; ifd.in_ready = 1'b0; ifd.in_num = '0;

        test_reset();
        test_unsigned_255();
        test_back_to_back();
        test_overflow();
        test_signed();
        test_backpressure();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
